// File: rtl/rf_arb_pkg.sv
// Shared types and sizing for the register-file write arbiter.
// Optional feature macro: RF_WRITE_ARB_PRIO0_EN (see rf_write_arbiter.sv).
package rf_arb_pkg;

  typedef enum logic {
    ST_INIT,
    ST_ARB
  } rf_arb_state_t;

  localparam int RF_AW    = 5;
  localparam int RF_DW    = 16;
  localparam int RF_NREGS = 32;

endpackage

// File: rtl/rf_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr_i.
// Returns a one-hot grant, its index and a valid flag.
module rf_rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [PW-1:0]   idx_o,
  output logic            vld_o
);

  int j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr_i) + k) % NREQ;
      if (en_i && !vld_o && req_i[j]) begin
        vld_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter with post-reset zero sweep.
// Macro RF_WRITE_ARB_PRIO0_EN: requester 0 gets absolute priority.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int AW   = RF_AW,
  parameter  int DW   = RF_DW,
  localparam int PW   = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init_start,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]  req_ready,
  output logic [AW-1:0]    Rw,
  output logic             WrEn,
  output logic [DW-1:0]    busW,
  output logic [PW-1:0]    grant_id,
  output logic             init_done
);

  rf_arb_state_t state_q, state_d;
  logic [AW-1:0] sweep_q, sweep_d;
  logic [PW-1:0] rr_q, rr_d;
  logic [AW-1:0] rw_q, rw_d;
  logic [DW-1:0] busw_q, busw_d;
  logic [PW-1:0] gid_q, gid_d;
  logic          wren_q, wren_d;
  logic          done_q, done_d;

  logic            arb_en;
  logic [NREQ-1:0] rr_req;
  logic [NREQ-1:0] rr_gnt;
  logic [PW-1:0]   rr_idx;
  logic            rr_vld;
  logic [PW-1:0]   g_idx;
  logic            g_vld;
  logic            adv;

  assign arb_en = (state_q == ST_ARB) && !init_start;

  rf_rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req_i (rr_req),
    .ptr_i (rr_q),
    .en_i  (arb_en),
    .gnt_o (rr_gnt),
    .idx_o (rr_idx),
    .vld_o (rr_vld)
  );

`ifdef RF_WRITE_ARB_PRIO0_EN
  // Requester 0 bypasses the ring and leaves the pointer untouched.
  assign rr_req = {req_valid[NREQ-1:1], 1'b0};

  always_comb begin
    req_ready = rr_gnt;
    g_idx     = rr_idx;
    g_vld     = rr_vld;
    adv       = rr_vld;
    if (arb_en && req_valid[0]) begin
      req_ready = NREQ'(1);
      g_idx     = '0;
      g_vld     = 1'b1;
      adv       = 1'b0;
    end
  end
`else
  assign rr_req    = req_valid;
  assign req_ready = rr_gnt;
  assign g_idx     = rr_idx;
  assign g_vld     = rr_vld;
  assign adv       = rr_vld;
`endif

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    rr_d    = rr_q;
    rw_d    = rw_q;
    busw_d  = busw_q;
    gid_d   = gid_q;
    wren_d  = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        wren_d  = 1'b1;
        rw_d    = sweep_q;
        busw_d  = '0;
        sweep_d = sweep_q + 1'b1;
        if (&sweep_q) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (init_start) begin
          state_d = ST_INIT;
          sweep_d = '0;
        end else if (g_vld) begin
          wren_d = 1'b1;
          rw_d   = req_addr[g_idx*AW +: AW];
          busw_d = req_data[g_idx*DW +: DW];
          gid_d  = g_idx;
          if (adv) begin
            rr_d = (g_idx == PW'(NREQ-1)) ? '0 : g_idx + 1'b1;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
    done_d = (state_d == ST_ARB);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_INIT;
      sweep_q <= '0;
      rr_q    <= '0;
      rw_q    <= '0;
      busw_q  <= '0;
      gid_q   <= '0;
      wren_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      rr_q    <= rr_d;
      rw_q    <= rw_d;
      busw_q  <= busw_d;
      gid_q   <= gid_d;
      wren_q  <= wren_d;
      done_q  <= done_d;
    end
  end

  assign Rw        = rw_q;
  assign WrEn      = wren_q;
  assign busW      = busw_q;
  assign grant_id  = gid_q;
  assign init_done = done_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter (NREQ=4, AW=5, DW=16).
// Table of single-cycle grants plus hand-written sweep/reset sequences.
module tb_rf_write_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 5;
  localparam int DW   = 16;

  logic             clk;
  logic             rst;
  logic             init_start;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]  req_ready;
  logic [AW-1:0]    Rw;
  logic             WrEn;
  logic [DW-1:0]    busW;
  logic [1:0]       grant_id;
  logic             init_done;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] rf [32];

  rf_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .init_start (init_start),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .Rw         (Rw),
    .WrEn       (WrEn),
    .busW       (busW),
    .grant_id   (grant_id),
    .init_done  (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file fed by the write port.
  always @(posedge clk) begin
    if (WrEn) rf[Rw] <= busW;
  end

  typedef struct {
    logic [3:0]  v;
    logic [19:0] a;
    logic [63:0] d;
    logic [3:0]  rdy;
    logic        wen;
    logic [4:0]  rw;
    logic [15:0] bw;
    logic [1:0]  gid;
  } vec_t;

  vec_t tv [7];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tv[0] = '{4'b0001, {5'd0, 5'd0, 5'd0, 5'd3},
              {16'h0, 16'h0, 16'h0, 16'hA5A5},
              4'b0001, 1'b1, 5'd3, 16'hA5A5, 2'd0};
    tv[1] = '{4'b0000, 20'd0, 64'd0,
              4'b0000, 1'b0, 5'd3, 16'hA5A5, 2'd0};
    tv[2] = '{4'b0011, {5'd0, 5'd0, 5'd2, 5'd1},
              {16'h0, 16'h0, 16'h2222, 16'h1111},
              4'b0010, 1'b1, 5'd2, 16'h2222, 2'd1};
    tv[3] = '{4'b1001, {5'd9, 5'd0, 5'd0, 5'd4},
              {16'h9999, 16'h0, 16'h0, 16'h4444},
              4'b1000, 1'b1, 5'd9, 16'h9999, 2'd3};
    tv[4] = '{4'b1001, {5'd9, 5'd0, 5'd0, 5'd4},
              {16'h9999, 16'h0, 16'h0, 16'h4444},
              4'b0001, 1'b1, 5'd4, 16'h4444, 2'd0};
    tv[5] = '{4'b0101, {5'd0, 5'd6, 5'd0, 5'd5},
              {16'h0, 16'h6666, 16'h0, 16'h5555},
              4'b0100, 1'b1, 5'd6, 16'h6666, 2'd2};
    tv[6] = '{4'b0001, {5'd0, 5'd0, 5'd0, 5'd8},
              {16'h0, 16'h0, 16'h0, 16'h0808},
              4'b0001, 1'b1, 5'd8, 16'h0808, 2'd0};

    rst        = 1'b0;
    init_start = 1'b0;
    req_valid  = '0;
    req_addr   = '0;
    req_data   = '0;
    #12;
    chk("rst_wren", WrEn, 0);
    chk("rst_rw", Rw, 0);
    chk("rst_busw", busW, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_done", init_done, 0);
    chk("rst_ready", req_ready, 0);

    // Post-reset sweep: Rw=0..31, zero data.
    rst = 1'b1;
    for (int c = 0; c < 32; c++) begin
      step();
      chk("sweep_wren", WrEn, 1);
      chk("sweep_rw", Rw, c);
      chk("sweep_busw", busW, 0);
      if (c < 31) chk("sweep_done", init_done, 0);
    end
    step();
    chk("idle_done", init_done, 1);
    chk("idle_wren", WrEn, 0);

    for (int i = 0; i < 7; i++) begin
      req_valid = tv[i].v;
      req_addr  = tv[i].a;
      req_data  = tv[i].d;
      #1;
      chk($sformatf("tv%0d_ready", i), req_ready, tv[i].rdy);
      step();
      req_valid = '0;
      chk($sformatf("tv%0d_wren", i), WrEn, tv[i].wen);
      chk($sformatf("tv%0d_rw", i), Rw, tv[i].rw);
      chk($sformatf("tv%0d_busw", i), busW, tv[i].bw);
      chk($sformatf("tv%0d_gid", i), grant_id, tv[i].gid);
    end

    // Same address from requesters 1 and 2, rr_ptr=1: last grant wins.
    req_valid = 4'b0110;
    req_addr  = {5'd0, 5'd7, 5'd7, 5'd0};
    req_data  = {16'h0, 16'h0022, 16'h0011, 16'h0};
    #1;
    chk("same_ready1", req_ready, 4'b0010);
    step();
    req_valid = 4'b0100;
    chk("same_bw1", busW, 16'h0011);
    chk("same_rw1", Rw, 7);
    #1;
    chk("same_ready2", req_ready, 4'b0100);
    step();
    req_valid = '0;
    chk("same_bw2", busW, 16'h0022);
    chk("same_gid2", grant_id, 2);
    step();
    chk("rf_r7", rf[7], 16'h0022);

    // rr_ptr=3 now; grant 3 once to bring it back to 0.
    req_valid = 4'b1000;
    req_addr  = {5'd20, 5'd21, 5'd22, 5'd23};
    req_data  = {16'hD3, 16'hD2, 16'hD1, 16'hD0};
    step();
    chk("rot_pre", grant_id, 3);
    req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("rot%0d_gid", c), grant_id, c % 4);
      chk($sformatf("rot%0d_wren", c), WrEn, 1);
    end
    req_valid = '0;
    step();

    // init_start with requester 2 waiting; ready stays low through sweep.
    req_valid  = 4'b0100;
    req_addr   = {5'd0, 5'd17, 5'd0, 5'd0};
    req_data   = {16'h0, 16'hBEEF, 16'h0, 16'h0};
    init_start = 1'b1;
    #1;
    chk("is_ready", req_ready, 0);
    step();
    init_start = 1'b0;
    chk("is_wren", WrEn, 0);
    chk("is_done", init_done, 0);
    for (int c = 0; c < 32; c++) begin
      chk($sformatf("is%0d_ready", c), req_ready, 0);
      init_start = (c == 5);
      step();
      init_start = 1'b0;
      chk($sformatf("is%0d_rw", c), Rw, c);
    end
    chk("is_arb_ready", req_ready, 4'b0100);
    step();
    req_valid = '0;
    chk("is_gid", grant_id, 2);
    chk("is_rw", Rw, 17);
    chk("is_busw", busW, 16'hBEEF);

    // Async reset mid-sweep at sweep_cnt=12.
    init_start = 1'b1;
    step();
    init_start = 1'b0;
    for (int c = 0; c < 12; c++) step();
    chk("mid_rw11", Rw, 11);
    rst = 1'b0;
    #1;
    chk("mid_wren", WrEn, 0);
    chk("mid_rw", Rw, 0);
    chk("mid_done", init_done, 0);
    rst = 1'b1;
    step();
    chk("rel_rw0", Rw, 0);
    chk("rel_wren", WrEn, 1);
    step();
    chk("rel_rw1", Rw, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
